dmem_arbiter: RTL

- Two-requester arbiter for the single data-memory port (OBI-style req/gnt/rvalid).
- Master 0 is the core load/store unit in the writeback stage. Master 1 is a secondary port (debug/DMA).
- Round-robin grant. One transaction outstanding at a time. Owner is held from request until response.
- Sits between the writeback stage and the data memory.

---
 rtl/riscv_defines.sv | 16 +
 rtl/dmem_rr_picker.sv | 36 +++
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
// Shared core definitions: data word width and the
// data-memory arbiter state encoding and master IDs.
package riscv_defines;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_GNT,
    ARB_WAIT_RSP
  } dmem_arb_state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/dmem_rr_picker.sv
// Round-robin winner select for the two data-memory masters.
// Priority flips to the other master after each completion.
module dmem_rr_picker
  import riscv_defines::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic done,
  input  logic done_owner,
  output logic winner,
  output logic prio
);

  // Priority register, handed to the other master on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= ARB_M0;
    end else if (done) begin
      prio <= ~done_owner;
    end
  end

  // Lone requester wins; a tie goes to the priority master
  always_comb begin
    winner = ARB_M0;
    unique case ({req1, req0})
      2'b01:   winner = ARB_M0;
      2'b10:   winner = ARB_M1;
      2'b11:   winner = prio;
      default: winner = ARB_M0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the data-memory port.
// Optional response timeout: define DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter
  import riscv_defines::*;
`ifdef DMEM_ARB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_data_req_i,
  input  logic [WORD_WIDTH-1:0] m0_data_addr_i,
  input  logic                  m0_data_we_i,
  input  logic [3:0]            m0_data_be_i,
  input  logic [WORD_WIDTH-1:0] m0_data_wdata_i,
  output logic                  m0_data_gnt_o,
  output logic                  m0_data_rvalid_o,
  output logic [WORD_WIDTH-1:0] m0_data_rdata_o,
  input  logic                  m1_data_req_i,
  input  logic [WORD_WIDTH-1:0] m1_data_addr_i,
  input  logic                  m1_data_we_i,
  input  logic [3:0]            m1_data_be_i,
  input  logic [WORD_WIDTH-1:0] m1_data_wdata_i,
  output logic                  m1_data_gnt_o,
  output logic                  m1_data_rvalid_o,
  output logic [WORD_WIDTH-1:0] m1_data_rdata_o,
`ifdef DMEM_ARB_TIMEOUT_EN
  output logic                  m0_data_err_o,
  output logic                  m1_data_err_o,
`endif
  output logic                  data_req_o,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [WORD_WIDTH-1:0] data_rdata_i
);

  dmem_arb_state_t state, state_d;
  logic owner, owner_load;
  logic winner, prio;
  logic sel, sel_valid;
  logic grant, rsp, own_req;
  logic rsp_ok;

  dmem_rr_picker u_picker (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (m0_data_req_i),
    .req1       (m1_data_req_i),
    .done       (rsp),
    .done_owner (owner),
    .winner     (winner),
    .prio       (prio)
  );

  assign own_req = (owner == ARB_M1) ? m1_data_req_i
                                     : m0_data_req_i;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
  logic          tmo;

  assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Response wait counter, held at zero outside WAIT_RSP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state != ARB_WAIT_RSP) begin
      cnt <= '0;
    end else if (!data_rvalid_i) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

  // State and owner registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      owner <= ARB_M0;
    end else begin
      state <= state_d;
      if (owner_load) owner <= winner;
    end
  end

  // Next state, selection and handshake strobes
  always_comb begin
    state_d    = state;
    owner_load = 1'b0;
    sel        = owner;
    sel_valid  = 1'b0;
    grant      = 1'b0;
    rsp        = 1'b0;
    rsp_ok     = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (m0_data_req_i || m1_data_req_i) begin
          sel        = winner;
          sel_valid  = 1'b1;
          owner_load = 1'b1;
          grant      = data_gnt_i;
          state_d    = data_gnt_i ? ARB_WAIT_RSP
                                  : ARB_WAIT_GNT;
        end
      end
      ARB_WAIT_GNT: begin
        if (own_req) begin
          sel_valid = 1'b1;
          if (data_gnt_i) begin
            grant   = 1'b1;
            state_d = ARB_WAIT_RSP;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_WAIT_RSP: begin
        if (data_rvalid_i) begin
          rsp     = 1'b1;
          rsp_ok  = 1'b1;
          state_d = ARB_IDLE;
        end
`ifdef DMEM_ARB_TIMEOUT_EN
        else if (tmo) begin
          rsp     = 1'b1;
          state_d = ARB_IDLE;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Memory-side request mux, zero when nobody is selected
  always_comb begin
    data_req_o   = sel_valid;
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (sel_valid && sel == ARB_M1) begin
      data_addr_o  = m1_data_addr_i;
      data_we_o    = m1_data_we_i;
      data_be_o    = m1_data_be_i;
      data_wdata_o = m1_data_wdata_i;
    end else if (sel_valid) begin
      data_addr_o  = m0_data_addr_i;
      data_we_o    = m0_data_we_i;
      data_be_o    = m0_data_be_i;
      data_wdata_o = m0_data_wdata_i;
    end
  end

  // Master-side responses, routed only to the selected/owner master
  always_comb begin
    m0_data_gnt_o    = grant && (sel == ARB_M0);
    m1_data_gnt_o    = grant && (sel == ARB_M1);
    m0_data_rvalid_o = rsp && (owner == ARB_M0);
    m1_data_rvalid_o = rsp && (owner == ARB_M1);
    m0_data_rdata_o  = '0;
    m1_data_rdata_o  = '0;
    if (rsp_ok && owner == ARB_M0) m0_data_rdata_o = data_rdata_i;
    if (rsp_ok && owner == ARB_M1) m1_data_rdata_o = data_rdata_i;
  end

`ifdef DMEM_ARB_TIMEOUT_EN
  assign m0_data_err_o = m0_data_rvalid_o && !rsp_ok;
  assign m1_data_err_o = m1_data_rvalid_o && !rsp_ok;
`endif

endmodule
